bitfusion_psum_accum: RTL

Downstream consumer of the fusion-unit top's registered 16-bit psum stream. Accumulates a programmed number of psum beats into a wide accumulator, forming one dot-product result per job. Presents the result on a valid/ready output handshake. Sits between the fusion tile and the output buffer / writeback logic.

---
 rtl/bitfusion_psum_accum.sv | 110 +++++++++++
 1 files changed

// File: rtl/bitfusion_psum_accum.sv
// bitfusion_psum_accum: accumulates len psum beats per job into one wide result with valid/ready output
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, len        job start pulse and beat count, sampled in IDLE or on the DONE handshake cycle
//   psum_signed       job treats psum as two's complement when 1, sampled with start
//   psum_valid, psum  incoming partial-sum beat stream (only consumed in ACCUM)
//   acc_out           completed dot-product result
//   out_valid         acc_out holds a completed result
//   out_ready         downstream accepts the result
//   busy              high while a job is accumulating or its result is pending
//   sat               a clamp happened in the current or last job
//
// Optional macro BITFUSION_ACC_SATURATE_EN: every add saturates and sat reports it;
// without it the accumulator wraps modulo 2^ACC_W and sat is tied low.
module bitfusion_psum_accum #(
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              psum_signed,
    input  logic              psum_valid,
    input  logic [PSUM_W-1:0] psum,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              sat
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]  count;
    logic              sgn;
    logic [ACC_W-1:0]  ext;
    logic [ACC_W-1:0]  sum;
    logic              take;

    assign ext  = sgn ? {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum} : {{(ACC_W-PSUM_W){1'b0}}, psum};
    // a new job is accepted from IDLE, or from DONE only when the pending result leaves this cycle
    assign take = start && (state == IDLE || (state == DONE && out_ready));
    assign busy = (state != IDLE);

`ifdef BITFUSION_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] U_MAX = '1;
    localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide;
    logic           clamp;
    logic           sat_q;

    // signed overflow: operands share a sign that the sum does not; unsigned overflow: carry out
    always_comb begin
        wide  = {1'b0, acc} + {1'b0, ext};
        clamp = sgn ? (acc[ACC_W-1] == ext[ACC_W-1]) && (wide[ACC_W-1] != acc[ACC_W-1]) : wide[ACC_W];
        sum   = !clamp ? wide[ACC_W-1:0] : !sgn ? U_MAX : acc[ACC_W-1] ? S_MIN : S_MAX;
    end

    assign sat = sat_q;
`else
    assign sum = acc + ext;
    assign sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            sgn       <= 1'b0;
            acc_out   <= '0;
            out_valid <= 1'b0;
`ifdef BITFUSION_ACC_SATURATE_EN
            sat_q     <= 1'b0;
`endif
        end else if (take) begin
            count     <= len;
            sgn       <= psum_signed;
            acc       <= '0;
            state     <= (len == '0) ? DONE : ACCUM;
            out_valid <= (len == '0);
            if (len == '0)
                acc_out <= '0;
`ifdef BITFUSION_ACC_SATURATE_EN
            sat_q     <= 1'b0;
`endif
        end else if (state == ACCUM && psum_valid) begin
            acc   <= sum;
            count <= count - 1'b1;
`ifdef BITFUSION_ACC_SATURATE_EN
            if (clamp)
                sat_q <= 1'b1;
`endif
            if (count == LEN_W'(1)) begin
                acc_out   <= sum;
                out_valid <= 1'b1;
                state     <= DONE;
            end
        end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
        end
    end
endmodule
